// File: rtl/hdmi_qsys_nios2_oci_dct_packer.sv
// hdmi_qsys_nios2_oci_dct_packer
// Packs 2-bit compressed-trace symbols into a 30-bit DCT accumulator and hands
// full or flushed partial frames downstream over a valid/ready port. Also
// reports the end-of-trace status (test_ending pulse, test_has_ended level).
module hdmi_qsys_nios2_oci_dct_packer #(
  parameter int SYM_W   = 2,
  parameter int NUM_SYM = 15,
  parameter int BUF_W   = 30,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sym_valid,
  input  logic [SYM_W-1:0]   sym_data,
  output logic               sym_ready,
  input  logic               flush,
  input  logic               trace_stop,
  output logic               frame_valid,
  output logic [BUF_W-1:0]   frame_data,
  output logic [CNT_W-1:0]   frame_count,
  input  logic               frame_ready,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               test_ending,
  output logic               test_has_ended
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SYM);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [BUF_W-1:0] ZERO_BUF = {BUF_W{1'b0}};

  state_e           state_q,  state_d;
  logic [BUF_W-1:0] buf_q,    buf_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             fvalid_q, fvalid_d;
  logic [BUF_W-1:0] fdata_q,  fdata_d;
  logic [CNT_W-1:0] fcount_q, fcount_d;
  logic             ending_q, ending_d;
  logic             ended_q,  ended_d;

  logic sym_ready_s;
  logic slot_free_s;
  logic xfer_s;
  logic accept_s;

  // Handshake qualifiers: symbols only enter while running with room left, and a
  // frame moves out when the slot is free and the accumulator is full or being flushed.
  always_comb begin
    sym_ready_s = (state_q == ST_RUN) && (cnt_q < FULL_CNT);
    slot_free_s = !fvalid_q || frame_ready;
    xfer_s      = slot_free_s && (cnt_q != ZERO_CNT) &&
                  ((cnt_q == FULL_CNT) || (state_q != ST_RUN));
    accept_s    = sym_valid && sym_ready_s;
  end

  // Next-state for accumulator, output frame slot and the trace-end FSM.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fvalid_d = fvalid_q;
    fdata_d  = fdata_q;
    fcount_d = fcount_q;
    ending_d = 1'b0;
    ended_d  = ended_q;

    // Accept and transfer are mutually exclusive: sym_ready is low whenever a transfer can fire.
    if (xfer_s) begin
      fdata_d  = buf_q;
      fcount_d = cnt_q;
      fvalid_d = 1'b1;
      buf_d    = ZERO_BUF;
      cnt_d    = ZERO_CNT;
    end else begin
      if (fvalid_q && frame_ready) begin
        fvalid_d = 1'b0;
      end else begin
        fvalid_d = fvalid_q;
      end
      if (accept_s) begin
        buf_d = {buf_q[BUF_W-SYM_W-1:0], sym_data};
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        buf_d = buf_q;
        cnt_d = cnt_q;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (trace_stop) begin
          state_d  = ST_DRAIN;
          ending_d = 1'b1;
        end else if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if ((cnt_q == ZERO_CNT) || xfer_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        // Done once nothing is accumulated and the last frame has left (or is leaving).
        if ((cnt_q == ZERO_CNT) && slot_free_s) begin
          state_d = ST_DONE;
          ended_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
        ended_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // All state registers; reset discards the accumulator and any held frame at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      buf_q    <= ZERO_BUF;
      cnt_q    <= ZERO_CNT;
      fvalid_q <= 1'b0;
      fdata_q  <= ZERO_BUF;
      fcount_q <= ZERO_CNT;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fvalid_q <= fvalid_d;
      fdata_q  <= fdata_d;
      fcount_q <= fcount_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
    end
  end

  assign sym_ready      = sym_ready_s;
  assign frame_valid    = fvalid_q;
  assign frame_data     = fdata_q;
  assign frame_count    = fcount_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = ending_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_hdmi_qsys_nios2_oci_dct_packer.sv
// Self-checking bench for hdmi_qsys_nios2_oci_dct_packer: a vector table of
// symbol bursts with hand-computed frames feeds a frame scoreboard, plus
// hand-written sequences for backpressure, empty flush, trace stop and reset.
module tb_hdmi_qsys_nios2_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready;
  logic        flush;
  logic        trace_stop;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int applied    = 0;
  int miscompares = 0;

  // n symbols; symbol k sits in syms[2k+1:2k]; exp_data/exp_cnt are the frame
  typedef struct packed {
    logic [4:0]  n;
    logic [29:0] syms;
    logic [29:0] exp_data;
    logic [3:0]  exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [29:0] data;
    logic [3:0]  cnt;
  } frame_t;

  frame_t exp_q[$];
  vec_t   tbl[7];

  hdmi_qsys_nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sym_valid      (sym_valid),
    .sym_data       (sym_data),
    .sym_ready      (sym_ready),
    .flush          (flush),
    .trace_stop     (trace_stop),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every frame handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_frame: got data 0x%0h count %0d, expected none", frame_data, frame_count);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        chk("frame_data", {2'b00, frame_data}, {2'b00, e.data});
        chk("frame_count", {28'd0, frame_count}, {28'd0, e.cnt});
      end
    end
  end

  // Starts and ends at posedge+1.
  task automatic send_sym(input logic [1:0] d);
    bit ok;
    ok = 1'b0;
    sym_valid = 1'b1;
    sym_data  = d;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sym_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("sym_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Waits until the scoreboard is empty and no frame is held; ends at posedge+1.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !frame_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sym_valid   = 1'b0;
    sym_data    = 2'd0;
    flush       = 1'b0;
    trace_stop  = 1'b0;
    frame_ready = 1'b0;
    reset_n     = 1'b0;

    tbl[0] = '{n: 5'd15, syms: 30'h24E4E4E4, exp_data: 30'h06C6C6C6, exp_cnt: 4'd15};
    tbl[1] = '{n: 5'd3,  syms: 30'h0000001B, exp_data: 30'h00000039, exp_cnt: 4'd3};
    tbl[2] = '{n: 5'd15, syms: 30'h3FFFFFFF, exp_data: 30'h3FFFFFFF, exp_cnt: 4'd15};
    tbl[3] = '{n: 5'd1,  syms: 30'h00000002, exp_data: 30'h00000002, exp_cnt: 4'd1};
    tbl[4] = '{n: 5'd5,  syms: 30'h00000001, exp_data: 30'h00000100, exp_cnt: 4'd5};
    tbl[5] = '{n: 5'd14, syms: 30'h05555555, exp_data: 30'h05555555, exp_cnt: 4'd14};
    tbl[6] = '{n: 5'd15, syms: 30'h26666666, exp_data: 30'h26666666, exp_cnt: 4'd15};

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_dct_count", {28'd0, dct_count}, 32'd0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_test_ending", {31'd0, test_ending}, 32'd0);
    do_reset();
    chk("rst_dct_buffer", {2'b00, dct_buffer}, 32'd0);
    chk("rst_frame_data", {2'b00, frame_data}, 32'd0);
    chk("rst_frame_count", {28'd0, frame_count}, 32'd0);
    chk("rst_test_has_ended", {31'd0, test_has_ended}, 32'd0);
    chk("rst_sym_ready", {31'd0, sym_ready}, 32'd1);

    // Vector table: full frames and flushed partial frames with a free sink
    frame_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      logic [29:0] s;
      s = tbl[i].syms;
      exp_q.push_back('{data: tbl[i].exp_data, cnt: tbl[i].exp_cnt});
      for (int k = 0; k < 15; k++) begin
        if (k < int'(tbl[i].n)) send_sym(s[2*k +: 2]);
      end
      if (tbl[i].n == 5'd15) begin
        @(negedge clk);
        chk("full_count_before_xfer", {28'd0, dct_count}, 32'd15);
        chk("full_ready_low", {31'd0, sym_ready}, 32'd0);
        @(negedge clk);
        chk("full_frame_valid", {31'd0, frame_valid}, 32'd1);
        chk("full_count_after_xfer", {28'd0, dct_count}, 32'd0);
        @(posedge clk); #1;
      end else begin
        pulse_flush();
        @(negedge clk);
        chk("flush_ready_low", {31'd0, sym_ready}, 32'd0);
        @(posedge clk); #1;
      end
      drain();
      chk("vec_dct_count_zero", {28'd0, dct_count}, 32'd0);
      chk("vec_back_in_run", {31'd0, sym_ready}, 32'd1);
    end

    // Backpressure: 30 symbols with the sink stalled
    frame_ready = 1'b0;
    exp_q.push_back('{data: 30'h06C6C6C6, cnt: 4'd15});
    exp_q.push_back('{data: 30'h3FFFFFFF, cnt: 4'd15});
    for (int k = 0; k < 15; k++) send_sym(2'(k % 4));
    for (int k = 0; k < 15; k++) send_sym(2'd3);
    @(negedge clk);
    chk("bp_sym_ready", {31'd0, sym_ready}, 32'd0);
    chk("bp_dct_count", {28'd0, dct_count}, 32'd15);
    chk("bp_held_valid", {31'd0, frame_valid}, 32'd1);
    chk("bp_held_data", {2'b00, frame_data}, 32'h06C6C6C6);
    @(posedge clk); #1;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", {31'd0, frame_valid}, 32'd1);
    chk("bp_second_data", {2'b00, frame_data}, 32'h3FFFFFFF);
    chk("bp_count_cleared", {28'd0, dct_count}, 32'd0);
    chk("bp_ready_again", {31'd0, sym_ready}, 32'd1);
    @(posedge clk); #1;
    frame_ready = 1'b1;
    drain();

    // Flush with an empty accumulator
    pulse_flush();
    @(negedge clk);
    chk("eflush_ready_low", {31'd0, sym_ready}, 32'd0);
    @(negedge clk);
    chk("eflush_ready_back", {31'd0, sym_ready}, 32'd1);
    chk("eflush_no_frame", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1;

    // Trace stop with 5 symbols pending
    frame_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_sym(2'd2);
    exp_q.push_back('{data: 30'h000002AA, cnt: 4'd5});
    trace_stop = 1'b1;
    @(posedge clk); #1;
    trace_stop = 1'b0;
    @(negedge clk);
    chk("stop_ending_pulse", {31'd0, test_ending}, 32'd1);
    chk("stop_ready_low", {31'd0, sym_ready}, 32'd0);
    @(negedge clk);
    chk("stop_ending_cleared", {31'd0, test_ending}, 32'd0);
    chk("stop_frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("stop_frame_count", {28'd0, frame_count}, 32'd5);
    chk("stop_not_ended_yet", {31'd0, test_has_ended}, 32'd0);
    @(posedge clk); #1;
    frame_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stop_has_ended", {31'd0, test_has_ended}, 32'd1);
    chk("stop_frame_gone", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1;
    sym_valid  = 1'b1;
    flush      = 1'b1;
    trace_stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_ready_low", {31'd0, sym_ready}, 32'd0);
      chk("done_count_zero", {28'd0, dct_count}, 32'd0);
      chk("done_no_ending", {31'd0, test_ending}, 32'd0);
    end
    chk("done_still_ended", {31'd0, test_has_ended}, 32'd1);
    @(posedge clk); #1;
    sym_valid  = 1'b0;
    flush      = 1'b0;
    trace_stop = 1'b0;

    // Async reset mid-cycle with a held frame and 7 accumulated symbols
    do_reset();
    frame_ready = 1'b0;
    for (int k = 0; k < 22; k++) send_sym(2'd1);
    #2;
    chk("pre_rst_count", {28'd0, dct_count}, 32'd7);
    chk("pre_rst_valid", {31'd0, frame_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", {28'd0, dct_count}, 32'd0);
    chk("async_rst_buffer", {2'b00, dct_buffer}, 32'd0);
    chk("async_rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("async_rst_data", {2'b00, frame_data}, 32'd0);
    chk("async_rst_fcount", {28'd0, frame_count}, 32'd0);
    chk("async_rst_ended", {31'd0, test_has_ended}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b1;
    exp_q.push_back('{data: 30'h00000039, cnt: 4'd3});
    send_sym(2'd3);
    send_sym(2'd2);
    send_sym(2'd1);
    pulse_flush();
    drain();
    chk("post_rst_count", {28'd0, dct_count}, 32'd0);
    chk("post_rst_ready", {31'd0, sym_ready}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
